point_report_sequencer: RTL and testbench

//  Frame-level controller that sequences the per-frame centroid results of the multi-point finder
//  out of the FPGA. On each frame end (VGA_VS falling edge) it snapshots all NUM_POINTS H/V

---
 rtl/point_report_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_point_report_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_report_sequencer.sv
// point_report_sequencer
// On every VGA_VS falling edge, snapshots the finder's NUM_POINTS H/V centroids
// and streams them out as one fixed-length byte packet:
//   HEADER_BYTE, FRAME_SEQ, NUM_POINTS, {H hi, H lo, V hi, V lo} x NUM_POINTS, XOR checksum
// Handshake: a byte moves on a clock edge where o_TX_VALID and i_TX_READY are
// both high; while o_TX_VALID is high and the byte has not been taken, o_TX_DATA
// holds. o_TX_VALID/o_TX_DATA are registers, so neither depends combinationally
// on i_TX_READY.
// A frame end that arrives while a packet is in flight is dropped and counted.
module point_report_sequencer #(
    parameter int         NUM_POINTS  = 8,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      VGA_VS,
    input  logic                      i_ENABLE,
    input  logic [16*NUM_POINTS-1:0]  i_POINTS_H,
    input  logic [16*NUM_POINTS-1:0]  i_POINTS_V,
    input  logic                      i_TX_READY,
    output logic [7:0]                o_TX_DATA,
    output logic                      o_TX_VALID,
    output logic                      o_BUSY,
    output logic [7:0]                o_FRAME_SEQ,
    output logic [7:0]                o_DROP_CNT,
    output logic [2:0]                o_DBG_STATE
);

    localparam logic [7:0] LAST_IDX = 8'(4*NUM_POINTS - 1);
    localparam logic [7:0] CNT_BYTE = 8'(NUM_POINTS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_HDR     = 3'd2,
        S_SEQ     = 3'd3,
        S_CNT     = 3'd4,
        S_PAYLOAD = 3'd5,
        S_CSUM    = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_vs;
    logic [16*NUM_POINTS-1:0]  r_sh_h;
    logic [16*NUM_POINTS-1:0]  r_sh_v;
    logic [7:0]                r_idx;
    logic [7:0]                w_idx_nxt;
    logic [7:0]                r_csum;
    logic [7:0]                r_seq;
    logic [7:0]                r_drop;
    logic                      r_tx_valid;
    logic                      w_valid_nxt;
    logic [7:0]                r_tx_data;
    logic [7:0]                w_data_nxt;
    logic                      w_frame_end;
    logic                      w_accept;
    logic [7:0]                w_pay_idx;
    logic [5:0]                w_slot;
    logic [15:0]               w_h_word;
    logic [15:0]               w_v_word;
    logic [7:0]                w_pay_byte;

    assign w_frame_end = r_vs & ~VGA_VS;
    assign w_accept    = r_tx_valid & i_TX_READY;

    // Index of the payload byte to present next: 0 when leaving CNT, else current + 1
    assign w_pay_idx = (r_state == S_PAYLOAD) ? (r_idx + 8'd1) : 8'd0;
    assign w_slot    = w_pay_idx[7:2];

    // Select the shadowed H/V word for the slot being presented next
    always_comb begin
        w_h_word = '0;
        w_v_word = '0;
        for (int k = 0; k < NUM_POINTS; k++) begin
            if (w_slot == 6'(k)) begin
                w_h_word = r_sh_h[16*k +: 16];
                w_v_word = r_sh_v[16*k +: 16];
            end
        end
    end

    // Byte order within a slot: H hi, H lo, V hi, V lo
    always_comb begin
        w_pay_byte = '0;
        case (w_pay_idx[1:0])
            2'd0:    w_pay_byte = w_h_word[15:8];
            2'd1:    w_pay_byte = w_h_word[7:0];
            2'd2:    w_pay_byte = w_v_word[15:8];
            default: w_pay_byte = w_v_word[7:0];
        endcase
    end

    // Next-state logic; also computes the next registered byte and valid flag
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_tx_valid;
        w_data_nxt  = r_tx_data;
        case (r_state)
            S_IDLE: begin
                if (w_frame_end && i_ENABLE) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_HDR;
                w_idx_nxt   = 8'd0;
                w_valid_nxt = 1'b1;
                w_data_nxt  = HEADER_BYTE;
            end
            S_HDR: begin
                if (w_accept) begin
                    w_state_nxt = S_SEQ;
                    w_data_nxt  = r_seq;
                end
            end
            S_SEQ: begin
                if (w_accept) begin
                    w_state_nxt = S_CNT;
                    w_data_nxt  = CNT_BYTE;
                end
            end
            S_CNT: begin
                if (w_accept) begin
                    w_state_nxt = S_PAYLOAD;
                    w_idx_nxt   = 8'd0;
                    w_data_nxt  = w_pay_byte;
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        // r_csum does not yet include the byte being accepted now
                        w_state_nxt = S_CSUM;
                        w_data_nxt  = r_csum ^ r_tx_data;
                    end else begin
                        w_idx_nxt  = r_idx + 8'd1;
                        w_data_nxt = w_pay_byte;
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_data_nxt  = 8'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_data_nxt  = 8'd0;
            end
        endcase
    end

    // State, output byte, VS edge detector and index registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_vs       <= 1'b0;
            r_idx      <= 8'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_vs       <= VGA_VS;
            r_idx      <= w_idx_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_data  <= w_data_nxt;
        end
    end

    // Shadow capture of the centroids one cycle after the frame end
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_sh_h <= '0;
            r_sh_v <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_sh_h <= i_POINTS_H;
            r_sh_v <= i_POINTS_V;
        end
    end

    // Running XOR of every accepted byte after the header
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_csum <= 8'd0;
        end else if (r_state == S_CAPTURE) begin
            r_csum <= 8'd0;
        end else if (w_accept && (r_state == S_SEQ || r_state == S_CNT || r_state == S_PAYLOAD)) begin
            r_csum <= r_csum ^ r_tx_data;
        end
    end

    // Packet sequence number, advanced when the checksum byte is taken
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_seq <= 8'd0;
        end else if (r_state == S_CSUM && w_accept) begin
            r_seq <= r_seq + 8'd1;
        end
    end

    // Saturating count of enabled frame ends that hit a busy sequencer
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_drop <= 8'd0;
        end else if (w_frame_end && i_ENABLE && r_state != S_IDLE && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign o_TX_DATA   = r_tx_data;
    assign o_TX_VALID  = r_tx_valid;
    assign o_BUSY      = (r_state != S_IDLE);
    assign o_FRAME_SEQ = r_seq;
    assign o_DROP_CNT  = r_drop;
    assign o_DBG_STATE = r_state;

endmodule

// File: tb/tb_point_report_sequencer.sv
// tb_point_report_sequencer
// Directed bench: drives frame ends and TX_READY patterns on the falling clock
// edge, samples outputs at the same falling edge, and checks each packet
// against a byte queue built from the centroids presented at capture time.
module tb_point_report_sequencer;

  localparam int NP = 8;

  logic            CLK;
  logic            RESET_N;
  logic            VGA_VS;
  logic            i_ENABLE;
  logic [16*NP-1:0] i_POINTS_H;
  logic [16*NP-1:0] i_POINTS_V;
  logic            i_TX_READY;
  logic [7:0]      o_TX_DATA;
  logic            o_TX_VALID;
  logic            o_BUSY;
  logic [7:0]      o_FRAME_SEQ;
  logic [7:0]      o_DROP_CNT;
  logic [2:0]      o_DBG_STATE;

  int n_cmp;
  int n_fail;
  int cycles;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  point_report_sequencer #(.NUM_POINTS(NP), .HEADER_BYTE(8'hA5)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .VGA_VS      (VGA_VS),
    .i_ENABLE    (i_ENABLE),
    .i_POINTS_H  (i_POINTS_H),
    .i_POINTS_V  (i_POINTS_V),
    .i_TX_READY  (i_TX_READY),
    .o_TX_DATA   (o_TX_DATA),
    .o_TX_VALID  (o_TX_VALID),
    .o_BUSY      (o_BUSY),
    .o_FRAME_SEQ (o_FRAME_SEQ),
    .o_DROP_CNT  (o_DROP_CNT),
    .o_DBG_STATE (o_DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    RESET_N = 1'b0;
    i_TX_READY = 1'b0;
    VGA_VS = 1'b0;
    step();
    RESET_N = 1'b1;
  endtask

  // VS high for one edge then low: the second edge is the detected frame end
  task automatic frame_end();
    VGA_VS = 1'b1;
    step();
    VGA_VS = 1'b0;
    step();
  endtask

  task automatic build_exp(input logic [7:0] seq);
    logic [7:0] cs;
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    exp_q.push_back(8'(NP));
    for (int k = 0; k < NP; k++) begin
      exp_q.push_back(i_POINTS_H[16*k+8 +: 8]);
      exp_q.push_back(i_POINTS_H[16*k +: 8]);
      exp_q.push_back(i_POINTS_V[16*k+8 +: 8]);
      exp_q.push_back(i_POINTS_V[16*k +: 8]);
    end
    cs = 8'd0;
    for (int i = 1; i < exp_q.size(); i++) cs = cs ^ exp_q[i];
    exp_q.push_back(cs);
  endtask

  // Receive `count` bytes; mode 0 = READY always 1, mode 1 = READY pattern 1,0,0,1
  task automatic recv(input int count, input int mode, input int budget);
    int c;
    logic held;
    logic [7:0] held_data;
    logic r;
    got_q = {};
    c = 0;
    held = 1'b0;
    held_data = 8'd0;
    while (got_q.size() < count && c < budget) begin
      r = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      i_TX_READY = r;
      if (held) begin
        check("valid_hold", {31'd0, o_TX_VALID}, 32'd1);
        check("data_stable", {24'd0, o_TX_DATA}, {24'd0, held_data});
      end
      if (o_TX_VALID && r) got_q.push_back(o_TX_DATA);
      held = o_TX_VALID && !r;
      held_data = o_TX_DATA;
      step();
      c++;
    end
    cycles = c;
    if (got_q.size() < count) check("recv_timeout", got_q.size(), count);
  endtask

  // Compare got_q against exp_q[first .. first+n-1]
  task automatic cmp_pkt(input string tag, input int first, input int n);
    check({tag, "_len"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[first+i]});
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    RESET_N = 1'b0;
    VGA_VS = 1'b0;
    i_ENABLE = 1'b0;
    i_TX_READY = 1'b0;
    i_POINTS_H = '0;
    i_POINTS_V = '0;
    step();
    step();
    check("rst_valid", {31'd0, o_TX_VALID}, 32'd0);
    check("rst_data", {24'd0, o_TX_DATA}, 32'd0);
    check("rst_busy", {31'd0, o_BUSY}, 32'd0);
    check("rst_seq", {24'd0, o_FRAME_SEQ}, 32'd0);
    check("rst_drop", {24'd0, o_DROP_CNT}, 32'd0);
    RESET_N = 1'b1;

    // Test 1: basic packet, READY always high
    i_ENABLE = 1'b1;
    i_POINTS_H[15:0] = 16'h0123;
    i_POINTS_V[15:0] = 16'h0456;
    build_exp(8'h00);
    frame_end();
    check("t1_valid_capture", {31'd0, o_TX_VALID}, 32'd0);
    check("t1_busy_capture", {31'd0, o_BUSY}, 32'd1);
    step();
    check("t1_valid_rise", {31'd0, o_TX_VALID}, 32'd1);
    check("t1_hdr", {24'd0, o_TX_DATA}, 32'hA5);
    recv(36, 0, 100);
    cmp_pkt("t1", 0, 36);
    check("t1_cycles", cycles, 36);
    check("t1_h0_lo", {24'd0, got_q[4]}, 32'h23);
    check("t1_csum", {24'd0, got_q[35]}, 32'h78);
    check("t1_seq_after", {24'd0, o_FRAME_SEQ}, 32'd1);
    check("t1_idle_valid", {31'd0, o_TX_VALID}, 32'd0);
    check("t1_idle_busy", {31'd0, o_BUSY}, 32'd0);

    // Test 2: READY pattern 1,0,0,1; inputs changed and ENABLE dropped after capture
    build_exp(8'h01);
    frame_end();
    step();
    i_POINTS_H = {NP{16'hBEEF}};
    i_POINTS_V = {NP{16'hCAFE}};
    i_ENABLE = 1'b0;
    recv(36, 1, 200);
    cmp_pkt("t2", 0, 36);
    check("t2_seq_after", {24'd0, o_FRAME_SEQ}, 32'd2);
    i_ENABLE = 1'b1;
    i_POINTS_H = '0;
    i_POINTS_V = '0;
    i_POINTS_H[15:0] = 16'h0123;
    i_POINTS_V[15:0] = 16'h0456;

    // Test 3: frame ends while stalled are dropped; frame end on the checksum edge too
    build_exp(8'h02);
    frame_end();
    step();
    i_TX_READY = 1'b1;
    check("t3_hdr", {24'd0, o_TX_DATA}, 32'hA5);
    step();
    i_TX_READY = 1'b0;
    check("t3_seq_byte", {24'd0, o_TX_DATA}, 32'h02);
    frame_end();
    frame_end();
    check("t3_drop2", {24'd0, o_DROP_CNT}, 32'd2);
    check("t3_stall_data", {24'd0, o_TX_DATA}, 32'h02);
    check("t3_stall_valid", {31'd0, o_TX_VALID}, 32'd1);
    recv(34, 0, 100);
    i_TX_READY = 1'b0;
    cmp_pkt("t3", 1, 34);
    check("t3_csum_valid", {31'd0, o_TX_VALID}, 32'd1);
    check("t3_csum", {24'd0, o_TX_DATA}, {24'd0, exp_q[35]});
    VGA_VS = 1'b1;
    step();
    VGA_VS = 1'b0;
    i_TX_READY = 1'b1;
    step();
    i_TX_READY = 1'b0;
    check("t3_drop3", {24'd0, o_DROP_CNT}, 32'd3);
    check("t3_seq_after", {24'd0, o_FRAME_SEQ}, 32'd3);
    repeat (5) step();
    check("t3_no_rearm_busy", {31'd0, o_BUSY}, 32'd0);
    check("t3_no_rearm_valid", {31'd0, o_TX_VALID}, 32'd0);

    // Test 4: frame end with ENABLE low is ignored
    reset_dut();
    i_ENABLE = 1'b0;
    frame_end();
    check("t4_valid", {31'd0, o_TX_VALID}, 32'd0);
    check("t4_busy", {31'd0, o_BUSY}, 32'd0);
    repeat (3) step();
    check("t4_busy_later", {31'd0, o_BUSY}, 32'd0);
    check("t4_drop", {24'd0, o_DROP_CNT}, 32'd0);
    i_ENABLE = 1'b1;
    build_exp(8'h00);
    frame_end();
    step();
    recv(36, 0, 100);
    cmp_pkt("t4", 0, 36);

    // Test 5: reset in the middle of the payload
    reset_dut();
    build_exp(8'h00);
    frame_end();
    step();
    recv(13, 0, 100);
    check("t5_pay10", {24'd0, o_TX_DATA}, {24'd0, exp_q[13]});
    RESET_N = 1'b0;
    i_TX_READY = 1'b0;
    step();
    RESET_N = 1'b1;
    check("t5_valid", {31'd0, o_TX_VALID}, 32'd0);
    check("t5_busy", {31'd0, o_BUSY}, 32'd0);
    check("t5_seq", {24'd0, o_FRAME_SEQ}, 32'd0);
    frame_end();
    step();
    recv(36, 0, 100);
    cmp_pkt("t5", 0, 36);
    check("t5_seq_after", {24'd0, o_FRAME_SEQ}, 32'd1);

    // Test 6: 257 packets, sequence byte wraps
    reset_dut();
    for (int p = 0; p < 257; p++) begin
      for (int k = 0; k < NP; k++) begin
        i_POINTS_H[16*k +: 16] = 16'(p * 31 + k * 4099);
        i_POINTS_V[16*k +: 16] = ~16'(p * 17 + k * 257);
      end
      build_exp(8'(p));
      frame_end();
      step();
      recv(36, 0, 100);
      cmp_pkt("t6", 0, 36);
      check("t6_seq_byte", {24'd0, got_q[1]}, 32'(p % 256));
    end

    // Test 7: drop counter saturates
    reset_dut();
    build_exp(8'h00);
    frame_end();
    step();
    i_TX_READY = 1'b0;
    repeat (260) frame_end();
    check("t7_drop_sat", {24'd0, o_DROP_CNT}, 32'hFF);
    recv(36, 0, 100);
    cmp_pkt("t7", 0, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
